// File: rtl/alu_issue_sched_if.sv
// alu_issue_sched_if: dispatch, CDB wakeup, branch-resolution and issue bundle of the ALU issue scheduler
//   master : dispatch / CDB / branch side; drives disp_*, wake_*, br_*; receives disp_ready, iss_*
//   slave  : the scheduler; receives disp_*, wake_*, br_*; drives disp_ready, iss_*
//   wake_pd packs port k at [k*PREG_BITS +: PREG_BITS]
interface alu_issue_sched_if #(
    parameter int PREG_BITS = 6,
    parameter int ROB_BITS  = 4,
    parameter int BR_BITS   = 4,
    parameter int WAKE      = 2
);
    logic                       disp_valid;
    logic                       disp_ready;
    logic [PREG_BITS-1:0]       disp_ps1;
    logic [PREG_BITS-1:0]       disp_ps2;
    logic                       disp_rdy1;
    logic                       disp_rdy2;
    logic                       disp_imm_v;
    logic [31:0]                disp_imm;
    logic [3:0]                 disp_aluop;
    logic [4:0]                 disp_rd;
    logic [PREG_BITS-1:0]       disp_pd;
    logic [ROB_BITS-1:0]        disp_rob;
    logic [BR_BITS-1:0]         disp_brmask;
    logic [WAKE-1:0]            wake_valid;
    logic [WAKE*PREG_BITS-1:0]  wake_pd;
    logic                       br_valid;
    logic                       br_mispred;
    logic [$clog2(BR_BITS)-1:0] br_idx;
    logic                       iss_valid;
    logic [PREG_BITS-1:0]       iss_ps1;
    logic [PREG_BITS-1:0]       iss_ps2;
    logic                       iss_imm_v;
    logic [31:0]                iss_imm;
    logic [3:0]                 iss_aluop;
    logic [4:0]                 iss_rd;
    logic [PREG_BITS-1:0]       iss_pd;
    logic [ROB_BITS-1:0]        iss_rob;
    logic [BR_BITS-1:0]         iss_brmask;

    modport master (
        output disp_valid, disp_ps1, disp_ps2, disp_rdy1, disp_rdy2, disp_imm_v, disp_imm,
               disp_aluop, disp_rd, disp_pd, disp_rob, disp_brmask, wake_valid, wake_pd,
               br_valid, br_mispred, br_idx,
        input  disp_ready, iss_valid, iss_ps1, iss_ps2, iss_imm_v, iss_imm, iss_aluop,
               iss_rd, iss_pd, iss_rob, iss_brmask
    );

    modport slave (
        input  disp_valid, disp_ps1, disp_ps2, disp_rdy1, disp_rdy2, disp_imm_v, disp_imm,
               disp_aluop, disp_rd, disp_pd, disp_rob, disp_brmask, wake_valid, wake_pd,
               br_valid, br_mispred, br_idx,
        output disp_ready, iss_valid, iss_ps1, iss_ps2, iss_imm_v, iss_imm, iss_aluop,
               iss_rd, iss_pd, iss_rob, iss_brmask
    );
endinterface

// File: rtl/alu_issue_sched.sv
// alu_issue_sched: oldest-ready-first issue queue for the single ALU pipe
//   clk            in   clock
//   rst            in   asynchronous reset, active low
//   bus            slave modport of alu_issue_sched_if (dispatch, wakeup, branch, issue packet)
//   perf_issue_cnt out  (ALU_SCHED_PERF_EN only) cycles with iss_valid
//   perf_stall_cnt out  (ALU_SCHED_PERF_EN only) cycles with a resident entry but no winner
// Optional feature macro: ALU_SCHED_PERF_EN
module alu_issue_sched #(
    parameter int DEPTH     = 8,
    parameter int PREG_BITS = 6,
    parameter int ROB_BITS  = 4,
    parameter int BR_BITS   = 4,
    parameter int WAKE      = 2
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ALU_SCHED_PERF_EN
    output logic [31:0]        perf_issue_cnt,
    output logic [31:0]        perf_stall_cnt,
`endif
    alu_issue_sched_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     r_valid, r_rdy1, r_rdy2, r_imm_v;
    logic [PREG_BITS-1:0] r_ps1 [DEPTH];
    logic [PREG_BITS-1:0] r_ps2 [DEPTH];
    logic [PREG_BITS-1:0] r_pd [DEPTH];
    logic [31:0]          r_imm [DEPTH];
    logic [3:0]           r_aluop [DEPTH];
    logic [4:0]           r_rd [DEPTH];
    logic [ROB_BITS-1:0]  r_rob [DEPTH];
    logic [BR_BITS-1:0]   r_brmask [DEPTH];
    // r_age[i][j] set: entry i is older than entry j (only meaningful for valid pairs)
    logic [DEPTH-1:0]     r_age [DEPTH];
    logic [OW-1:0]        r_occ;

    logic [DEPTH-1:0]     w_req, w_win, w_kill, w_wk1, w_wk2, w_valid_nxt;
    logic [BR_BITS-1:0]   w_brclr;
    logic [IW-1:0]        w_free, w_sel;
    logic [OW-1:0]        w_occ_nxt;
    logic                 w_any, w_acc, w_wr, w_brk, w_brc, w_dwk1, w_dwk2;

    assign w_brk          = bus.br_valid & bus.br_mispred;
    assign w_brc          = bus.br_valid & ~bus.br_mispred;
    assign w_brclr        = w_brc ? (BR_BITS'(1) << bus.br_idx) : '0;
    assign bus.disp_ready = (r_occ != OW'(DEPTH));
    assign w_acc          = bus.disp_valid & bus.disp_ready;
    // an accepted op depending on the branch being squashed is simply not written
    assign w_wr           = w_acc & ~(w_brk & bus.disp_brmask[bus.br_idx]);

    always_comb begin
        w_dwk1    = 1'b0;
        w_dwk2    = 1'b0;
        w_wk1     = '0;
        w_wk2     = '0;
        w_kill    = '0;
        w_req     = '0;
        w_win     = '0;
        w_free    = '0;
        w_sel     = '0;
        w_any     = 1'b0;
        w_occ_nxt = '0;
        for (int k = 0; k < WAKE; k++) begin
            w_dwk1 |= bus.wake_valid[k] & (bus.wake_pd[k*PREG_BITS +: PREG_BITS] == bus.disp_ps1);
            w_dwk2 |= bus.wake_valid[k] & (bus.wake_pd[k*PREG_BITS +: PREG_BITS] == bus.disp_ps2);
        end
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!r_valid[i]) w_free = IW'(i);
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < WAKE; k++) begin
                w_wk1[i] |= bus.wake_valid[k] & (bus.wake_pd[k*PREG_BITS +: PREG_BITS] == r_ps1[i]);
                w_wk2[i] |= bus.wake_valid[k] & (bus.wake_pd[k*PREG_BITS +: PREG_BITS] == r_ps2[i]);
            end
            w_kill[i] = r_valid[i] & w_brk & r_brmask[i][bus.br_idx];
            w_req[i]  = r_valid[i] & r_rdy1[i] & (r_rdy2[i] | r_imm_v[i]) & ~w_kill[i];
        end
        // winner: a requester with no older requester; at most one such entry exists
        for (int i = 0; i < DEPTH; i++) begin
            w_win[i] = w_req[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && w_req[j] && r_age[j][i]) w_win[i] = 1'b0;
            if (w_win[i]) begin
                w_sel = IW'(i);
                w_any = 1'b1;
            end
        end
        w_valid_nxt = r_valid & ~w_kill & ~(w_any ? (DEPTH'(1) << w_sel) : '0);
        if (w_wr) w_valid_nxt[w_free] = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            w_occ_nxt += OW'(w_valid_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid        <= '0;
            r_rdy1         <= '0;
            r_rdy2         <= '0;
            r_imm_v        <= '0;
            r_occ          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ps1[i]    <= '0;
                r_ps2[i]    <= '0;
                r_pd[i]     <= '0;
                r_imm[i]    <= '0;
                r_aluop[i]  <= '0;
                r_rd[i]     <= '0;
                r_rob[i]    <= '0;
                r_brmask[i] <= '0;
                r_age[i]    <= '0;
            end
            bus.iss_valid  <= 1'b0;
            bus.iss_ps1    <= '0;
            bus.iss_ps2    <= '0;
            bus.iss_imm_v  <= 1'b0;
            bus.iss_imm    <= '0;
            bus.iss_aluop  <= '0;
            bus.iss_rd     <= '0;
            bus.iss_pd     <= '0;
            bus.iss_rob    <= '0;
            bus.iss_brmask <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            r_rdy1  <= r_rdy1 | w_wk1;
            r_rdy2  <= r_rdy2 | w_wk2;
            for (int i = 0; i < DEPTH; i++)
                r_brmask[i] <= r_brmask[i] & ~w_brclr;
            if (w_wr) begin
                r_ps1[w_free]    <= bus.disp_ps1;
                r_ps2[w_free]    <= bus.disp_ps2;
                r_rdy1[w_free]   <= bus.disp_rdy1 | w_dwk1;
                r_rdy2[w_free]   <= bus.disp_rdy2 | bus.disp_imm_v | w_dwk2;
                r_imm_v[w_free]  <= bus.disp_imm_v;
                r_imm[w_free]    <= bus.disp_imm;
                r_aluop[w_free]  <= bus.disp_aluop;
                r_rd[w_free]     <= bus.disp_rd;
                r_pd[w_free]     <= bus.disp_pd;
                r_rob[w_free]    <= bus.disp_rob;
                r_brmask[w_free] <= bus.disp_brmask & ~w_brclr;
                // newcomer is younger than everything already resident
                for (int j = 0; j < DEPTH; j++) begin
                    r_age[w_free][j] <= 1'b0;
                    if (IW'(j) != w_free) r_age[j][w_free] <= 1'b1;
                end
            end
            bus.iss_valid <= w_any;
            if (w_any) begin
                bus.iss_ps1    <= r_ps1[w_sel];
                bus.iss_ps2    <= r_ps2[w_sel];
                bus.iss_imm_v  <= r_imm_v[w_sel];
                bus.iss_imm    <= r_imm[w_sel];
                bus.iss_aluop  <= r_aluop[w_sel];
                bus.iss_rd     <= r_rd[w_sel];
                bus.iss_pd     <= r_pd[w_sel];
                bus.iss_rob    <= r_rob[w_sel];
                bus.iss_brmask <= r_brmask[w_sel] & ~w_brclr;
            end
        end
    end

`ifdef ALU_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_issue_cnt <= perf_issue_cnt + 32'(bus.iss_valid);
            perf_stall_cnt <= perf_stall_cnt + 32'((|r_valid) & ~w_any);
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_sched.sv
// tb_alu_issue_sched: random dispatch/wakeup/branch traffic against an age-ordered list model
module tb_alu_issue_sched;
    localparam int DEPTH = 8, PB = 6, RB = 4, BB = 4, WK = 2;
    localparam int PW = 3 * PB + RB + BB + 42;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_issue_sched_if #(.PREG_BITS(PB), .ROB_BITS(RB), .BR_BITS(BB), .WAKE(WK)) bus ();
`ifdef ALU_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

    alu_issue_sched #(.DEPTH(DEPTH), .PREG_BITS(PB), .ROB_BITS(RB), .BR_BITS(BB), .WAKE(WK)) dut (
        .clk(clk),
        .rst(rst),
`ifdef ALU_SCHED_PERF_EN
        .perf_issue_cnt(perf_issue_cnt),
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PB-1:0] ps1, ps2;
        bit            r1, r2, imm_v;
        logic [31:0]   imm;
        logic [3:0]    aluop;
        logic [4:0]    rd;
        logic [PB-1:0] pd;
        logic [RB-1:0] rob;
        logic [BB-1:0] brm;
    } ent_t;

    typedef struct {
        bit            v;
        logic [PW-1:0] p;
    } exp_t;

    ent_t mq[$];   // resident ops, oldest first
    exp_t sb[$];   // expected issue-port contents, one per cycle
    int vectors = 0;
    int errors  = 0;

    task automatic chk(string name, logic [PW-1:0] got, logic [PW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pk(ent_t e);
        return {e.ps1, e.ps2, e.imm_v, e.imm, e.aluop, e.rd, e.pd, e.rob, e.brm};
    endfunction

    function automatic logic [PW-1:0] dut_pk();
        return {bus.iss_ps1, bus.iss_ps2, bus.iss_imm_v, bus.iss_imm, bus.iss_aluop,
                bus.iss_rd, bus.iss_pd, bus.iss_rob, bus.iss_brmask};
    endfunction

    function automatic bit hit(logic [WK-1:0] wv, logic [WK*PB-1:0] wp, logic [PB-1:0] t);
        bit h = 0;
        for (int k = 0; k < WK; k++)
            if (wv[k] && wp[k*PB +: PB] == t) h = 1;
        return h;
    endfunction

    task automatic idle();
        bus.disp_valid  = 0; bus.disp_ps1 = '0; bus.disp_ps2 = '0; bus.disp_rdy1 = 0;
        bus.disp_rdy2   = 0; bus.disp_imm_v = 0; bus.disp_imm = '0; bus.disp_aluop = '0;
        bus.disp_rd     = '0; bus.disp_pd = '0; bus.disp_rob = '0; bus.disp_brmask = '0;
        bus.wake_valid  = '0; bus.wake_pd = '0;
        bus.br_valid    = 0; bus.br_mispred = 0; bus.br_idx = '0;
    endtask

    // one cycle: random inputs, model update, expected issue pushed for the coming edge
    task automatic step(int pd, int pw, int pbr, int pr);
        ent_t d, w;
        ent_t nq[$];
        bit won = 0, dv, bv, bm, brk;
        logic [1:0] bi;
        logic [BB-1:0] clr;
        logic [WK-1:0] wv;
        logic [WK*PB-1:0] wp;
        int occ = mq.size();
        dv      = $urandom_range(99) < pd;
        d.ps1   = PB'($urandom_range(15));
        d.ps2   = PB'($urandom_range(15));
        d.r1    = $urandom_range(99) < pr;
        d.r2    = $urandom_range(99) < pr;
        d.imm_v = $urandom_range(3) == 0;
        d.imm   = $urandom;
        d.aluop = 4'($urandom);
        d.rd    = 5'($urandom);
        d.pd    = PB'($urandom);
        d.rob   = RB'($urandom);
        d.brm   = ($urandom_range(3) == 0) ? BB'($urandom) : '0;
        for (int k = 0; k < WK; k++) begin
            wv[k]          = $urandom_range(99) < pw;
            wp[k*PB +: PB] = PB'($urandom_range(15));
        end
        bv = $urandom_range(99) < pbr;
        bm = $urandom_range(1) == 1;
        bi = 2'($urandom);
        bus.disp_valid = dv; bus.disp_ps1 = d.ps1; bus.disp_ps2 = d.ps2; bus.disp_rdy1 = d.r1;
        bus.disp_rdy2 = d.r2; bus.disp_imm_v = d.imm_v; bus.disp_imm = d.imm;
        bus.disp_aluop = d.aluop; bus.disp_rd = d.rd; bus.disp_pd = d.pd; bus.disp_rob = d.rob;
        bus.disp_brmask = d.brm; bus.wake_valid = wv; bus.wake_pd = wp;
        bus.br_valid = bv; bus.br_mispred = bm; bus.br_idx = bi;
        chk("disp_ready", PW'(bus.disp_ready), PW'(occ != DEPTH));
        brk = bv && bm;
        clr = (bv && !bm) ? (BB'(1) << bi) : '0;
        foreach (mq[i]) begin
            if (brk && mq[i].brm[bi]) continue;
            if (!won && mq[i].r1 && (mq[i].r2 || mq[i].imm_v)) begin
                won = 1;
                w   = mq[i];
            end else nq.push_back(mq[i]);
        end
        foreach (nq[i]) begin
            nq[i].r1  = nq[i].r1 | hit(wv, wp, nq[i].ps1);
            nq[i].r2  = nq[i].r2 | hit(wv, wp, nq[i].ps2);
            nq[i].brm = nq[i].brm & ~clr;
        end
        if (dv && occ != DEPTH && !(brk && d.brm[bi])) begin
            d.r1  = d.r1 | hit(wv, wp, d.ps1);
            d.r2  = d.r2 | d.imm_v | hit(wv, wp, d.ps2);
            d.brm = d.brm & ~clr;
            nq.push_back(d);
        end
        w.brm = w.brm & ~clr;
        sb.push_back('{v: won, p: won ? pk(w) : '0});
        mq = nq;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("iss_valid", PW'(bus.iss_valid), PW'(e.v));
                if (e.v) chk("iss_pkt", dut_pk(), e.p);
            end
        end
    end

    initial begin : driver
        idle();
        #1 rst = 0;
        #11;
        chk("reset_iss_valid", PW'(bus.iss_valid), PW'(0));
        chk("reset_disp_ready", PW'(bus.disp_ready), PW'(1));
        chk("reset_iss_pkt", dut_pk(), '0);
        @(posedge clk);
        #2 rst = 1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (c == 1200) begin
                idle();
                #2 rst = 0;
                #1;
                chk("midrst_iss_valid", PW'(bus.iss_valid), PW'(0));
                chk("midrst_disp_ready", PW'(bus.disp_ready), PW'(1));
                sb.delete();
                mq.delete();
                @(posedge clk);
                #2 rst = 1;
            end else if (c < 300) step(90, 5, 3, 25);
            else if (c < 1600) step(50, 40, 10, 60);
            else step(20, 60, 5, 50);
        end
        @(negedge clk);
        idle();
        repeat (3) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
